// File: rtl/bus_demux_pkg.sv
// Shared constants and types for the 8-way bus demux.
// Channel count, select/count widths and slot state enum.
package bus_demux_pkg;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/bus_demux_8ch_if.sv
// Upstream and per-channel downstream signals of the demux.
// slave: demux side; master: bus source and consumers side.
interface bus_demux_8ch_if #(
  parameter int n = 16
);
  import bus_demux_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_bcast;
  logic [n-1:0]         in_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*n-1:0]     out_data;
  logic [CNT_W-1:0]     acc_count;

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, acc_count
  );

  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data, acc_count
  );
endinterface

// File: rtl/demux_slot.sv
// One holding slot: EMPTY/FULL with drain-and-reload.
// Ports: Clock, Resetn, load, load_data, out_ready, out_valid, out_data, free.
module demux_slot
  import bus_demux_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         load,
  input  logic [n-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  output logic         free
);
  slot_state_t  state_q, state_d;
  logic [n-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (state_q == SLOT_FULL && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  // a draining slot can take a new word in the same cycle
  assign free      = (state_q == SLOT_EMPTY) | out_ready;
endmodule

// File: rtl/bus_demux_8ch.sv
// 8-way demux steering one word/cycle into per-channel slots.
// Ports: Clock, Resetn, bus (slave): in_* handshake, out_* per channel, acc_count.
module bus_demux_8ch
  import bus_demux_pkg::*;
#(
  parameter int n = 16
) (
  input  logic            Clock,
  input  logic            Resetn,
  bus_demux_8ch_if.slave  bus
);
  logic [NCH-1:0]   free;
  logic [NCH-1:0]   sel_oh;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   out_valid;
  logic [NCH*n-1:0] out_data;
  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;

  assign sel_oh = NCH'(1) << bus.in_sel;

  // in_ready ignores in_valid and is held low during reset
  assign in_ready = Resetn &
    (bus.in_bcast ? &free : free[bus.in_sel]);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load = bus.in_bcast ? '1 : sel_oh;
    end
  end

  always_comb begin
    acc_count_d = acc_count_q + CNT_W'(accept);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc_count_q <= '0;
    end else begin
      acc_count_q <= acc_count_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.n(n)) u_slot (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*n +: n]),
      .free      (free[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.acc_count = acc_count_q;
endmodule

// File: tb/tb_bus_demux_8ch.sv
// Bench for bus_demux_8ch: directed plan plus random traffic.
// Outputs are compared against a per-channel slot model.
module tb_bus_demux_8ch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_demux_8ch_if #(.n(16)) bus ();

  bus_demux_8ch #(.n(16)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  bit          m_full [8];
  logic [15:0] m_word [8];
  logic [15:0] m_cnt;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit m_ready();
    int nfree = 0;
    if (!rst_n) return 1'b0;
    for (int k = 0; k < 8; k++)
      if (!m_full[k] || bus.out_ready[k]) nfree++;
    if (bus.in_bcast) return nfree == 8;
    return !m_full[bus.in_sel] || bus.out_ready[bus.in_sel];
  endfunction

  function automatic logic [7:0] m_valid();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [127:0] m_data();
    logic [127:0] d = '0;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = m_word[k];
    return d;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = 16'h0;
    end
    m_cnt = 16'h0;
  endtask

  task automatic chk_out(string tag);
    chk({tag, ".valid"}, 128'(bus.out_valid), 128'(m_valid()));
    chk({tag, ".data"}, bus.out_data, m_data());
    chk({tag, ".cnt"}, 128'(bus.acc_count), 128'(m_cnt));
  endtask

  // called just after a falling edge; returns just after the next one
  task automatic step(bit v, bit [2:0] s, bit b, bit [15:0] d,
                      bit [7:0] r, bit c);
    bit acc;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_bcast  = b;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    if (c) chk("in_ready", 128'(bus.in_ready), 128'(m_ready()));
    acc = v && m_ready();
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (acc && (b || s == 3'(k))) begin
        m_full[k] = 1'b1;
        m_word[k] = d;
      end else if (m_full[k] && r[k]) begin
        m_full[k] = 1'b0;
      end
    end
    if (acc) m_cnt = m_cnt + 16'd1;
    #1;
    if (c) chk_out("step");
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = 16'h1234;
    bus.out_ready = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", 128'(bus.out_valid), 128'h0);
    chk("rst.data", bus.out_data, 128'h0);
    chk("rst.cnt", 128'(bus.acc_count), 128'h0);
    chk("rst.in_ready", 128'(bus.in_ready), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 128'(bus.in_ready), 128'h1);

    // single route to channel 5, then blocked second word
    step(1, 5, 0, 16'h00A5, 8'h00, 1);
    chk("route.valid", 128'(bus.out_valid), 128'h20);
    chk("route.data5", 128'(bus.out_data[80 +: 16]), 128'h00A5);
    chk("route.cnt", 128'(bus.acc_count), 128'h1);
    step(1, 5, 0, 16'h0055, 8'h00, 1);
    chk("route.blocked", 128'(bus.out_data[80 +: 16]), 128'h00A5);
    step(1, 5, 0, 16'h0055, 8'h20, 1);

    // back-to-back into channel 2 while it drains
    for (int i = 1; i <= 4; i++) begin
      step(1, 2, 0, 16'(i), 8'h04, 1);
      chk("b2b.data2", 128'(bus.out_data[32 +: 16]), 128'(i));
    end

    // clear all slots, then independence check
    step(0, 0, 0, 16'h0, 8'hFF, 1);
    step(1, 3, 0, 16'h3333, 8'h00, 1);
    step(1, 6, 0, 16'hBEEF, 8'h00, 1);
    chk("indep.valid", 128'(bus.out_valid), 128'h48);

    // broadcast blocked by stalled channel 0
    step(0, 0, 0, 16'h0, 8'hFF, 1);
    step(1, 0, 0, 16'h0A0A, 8'h00, 1);
    step(1, 4, 1, 16'h7777, 8'h00, 1);
    chk("bcast.blocked", 128'(bus.out_valid), 128'h01);
    step(1, 4, 1, 16'h7777, 8'h01, 1);
    chk("bcast.valid", 128'(bus.out_valid), 128'hFF);
    chk("bcast.data", bus.out_data, {8{16'h7777}});

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, 3'($urandom), $urandom % 8 == 0,
           16'($urandom), 8'($urandom), 1);

    // counter wrap: channel 0 drains every cycle so each word is taken
    while (m_cnt != 16'hFFFF)
      step(1, 0, 0, 16'($urandom), 8'h01, 0);
    chk("wrap.pre", 128'(bus.acc_count), 128'hFFFF);
    step(1, 0, 0, 16'hCAFE, 8'h01, 1);
    chk("wrap.post", 128'(bus.acc_count), 128'h0);

    // fill every slot, stall, then reset between edges
    step(1, 0, 1, 16'h5A5A, 8'hFF, 1);
    bus.out_ready = 8'h00;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst.valid", 128'(bus.out_valid), 128'h0);
    chk("arst.data", bus.out_data, 128'h0);
    chk("arst.cnt", 128'(bus.acc_count), 128'h0);
    chk("arst.in_ready", 128'(bus.in_ready), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 7, 0, 16'h0777, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_demux_8ch.md
Name: bus_demux_8ch

Overview:
- 8-way demultiplexing distributor; the write-side counterpart of the 8:1 bus source mux in the datapath.
- Accepts one (destination, data) word per cycle over a valid/ready handshake and steers it into one of 8 per-channel holding slots. Each slot presents its word to its consumer with an independent valid/ready handshake.
- Broadcast mode writes the same word into all 8 slots at once.
- Sits between the shared processor bus and register/peripheral write ports.

Parameters:
- n, 16, data width of bus and of every channel.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept the presented word this cycle (combinational).
- in_sel  in  3  destination channel 0..7; ignored when in_bcast=1.
- in_bcast  in  1  write word to all 8 channels.
- in_data  in  n  word to deliver.
- out_valid  out  8  bit k: channel k slot holds an undelivered word.
- out_ready  in  8  bit k: channel k consumer accepts this cycle.
- out_data  out  8*n  channel k word at bits [k*n +: n].
- acc_count  out  16  number of accepted input words, wraps modulo 2^16.

Behaviour:
- Reset (Resetn=0, asynchronous, any time including mid-transfer):
  - out_valid=0, out_data=0, acc_count=0 immediately.
  - Any held words are discarded.
  - in_ready is 0 while Resetn=0.
- Each slot is a 2-state FSM:
  - EMPTY (out_valid[k]=0) -> FULL on load.
  - FULL -> EMPTY when out_ready[k]=1 and there is no simultaneous load.
  - FULL -> FULL with new data when out_ready[k]=1 and a load occurs in the same cycle (drain and reload).
  - FULL with out_ready[k]=0 holds data and valid unchanged.
- Slot k is free when out_valid[k]=0 or out_ready[k]=1.
- in_ready:
  - in_bcast=0: equals free(in_sel).
  - in_bcast=1: equals the AND of free(k) for all k.
  - Depends on in_sel and in_bcast but never on in_valid.
- Accept occurs when in_valid & in_ready. On accept:
  - The target slot (or all 8 if in_bcast=1) loads in_data and sets out_valid on the next edge.
  - acc_count increments by 1, including for broadcast.
- Latency: 1 cycle from accepting edge to out_valid/out_data visible.
- Throughput: 1 word/cycle to the same channel when its consumer holds out_ready=1.
- Channels are independent: a stalled channel k blocks only words addressed to k, and broadcasts.
- out_data[k] retains its last value after drain; it changes only on load or reset.
- out_ready[k] asserted while out_valid[k]=0 has no effect.
- in_valid=0: no state change except drains.
- acc_count wraps from 0xFFFF to 0x0000 with no flag.
- No combinational path from out_ready to out_valid/out_data; out_ready reaches only in_ready.

Decomposition:
- Shared package bus_demux_pkg:
  - NCH=8, SEL_W=3, CNT_W=16.
  - Enum slot_state_t {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_slot:
  - Parameter n.
  - Ports: Clock, Resetn, load, load_data, out_ready, out_valid, out_data, free.
  - Instantiated NCH times via generate.
- Top contains:
  - load decode: one-hot of in_sel, or all-ones for broadcast, ANDed with accept.
  - in_ready reduction.
  - acc_count.

Test Plan:
- Reset: hold Resetn=0 with in_valid=1, in_data=16'h1234 -> out_valid=8'h00, out_data=0, acc_count=0, in_ready=0. Release -> in_ready=1.
- Single route: in_sel=5, in_data=16'h00A5, all out_ready=0 -> next cycle out_valid=8'h20, channel 5 data=16'h00A5, acc_count=1. A second word to sel 5 -> in_ready=0 until out_ready[5]=1.
- Back-to-back: out_ready[2]=1, send 16'h0001..16'h0004 to sel 2 on 4 consecutive cycles -> in_ready stays 1, channel 2 shows 1,2,3,4 on successive cycles, acc_count=4.
- Independence: channel 3 full and stalled; a word to sel 6 (16'hBEEF) -> accepted the same cycle, out_valid=8'h48.
- Broadcast: in_bcast=1, in_data=16'h7777 with channel 0 full and stalled -> in_ready=0. Raise out_ready[0] -> accepted, all 8 channels =16'h7777, out_valid=8'hFF, acc_count increments by exactly 1.
- Wrap and reset mid-operation: preload acc_count to 0xFFFF via 65535 accepts, one more accept -> 0x0000. Then assert Resetn=0 asynchronously between clock edges while slots are full -> out_valid=8'h00 immediately.
